// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder cell plus a registered carry, LSB first, WIDTH cycles per result.
// Optional subtract mode is enabled with `define SERIAL_ADDER_SUB_EN (adds the `sub` input).

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// state | meaning
// IDLE  | waiting for start
// RUN   | one operand bit processed per edge, LSB first
// DONE  | result valid, done pulse; start here chains the next operation
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] work_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic             last_bit;
    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    full_adder u_full_adder (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_bit = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));

    // Subtraction is a + ~b + 1, so only the B load and the initial carry differ.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = start ? RUN : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            work_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_sr_q  <= a;
            b_sr_q  <= b_load;
            carry_q <= carry_load;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            a_sr_q  <= a_sr_q >> 1;
            b_sr_q  <= b_sr_q >> 1;
            work_q  <= {fa_sum, work_q[WIDTH-1:1]};
            carry_q <= fa_cout;
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    // Result registers hold the previous answer for the whole of RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (last_bit) begin
            sum  <= {fa_sum, work_q[WIDTH-1:1]};
            cout <= fa_cout;
        end
    end

endmodule
